// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter that feeds one UART byte engine
// from N_REQ byte-stream requesters.
// Optional feature: define ARB_TIMEOUT_EN to enable the tx_complete watchdog.
//
// Handshakes:
//   requester side: a requester holds req[i]/req_byte lane i/req_last[i] stable until it sees
//     the one-cycle byte_ack[i]; it then presents its next byte or drops req[i].
//   engine side: tx_start is a one-cycle pulse; tx_byte is held from tx_start until the
//     engine returns its one-cycle tx_complete pulse.
// dbg_state exposes the FSM state (ARB_IDLE=0, ARB_LOAD=1, ARB_WAIT=2) for checkers.
module uart_tx_arbiter #(
  parameter int                       N_REQ          = 4,
  parameter int                       TIMEOUT_WIDTH  = 14,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 14'd12000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_byte,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   byte_ack,
  output logic               tx_start,
  output logic [7:0]         tx_byte,
  input  logic               tx_complete,
  output logic               busy,
  output logic               timeout_err,
  output logic [1:0]         dbg_state
);

  localparam int               IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_LOAD = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  arb_state_t      state;
  arb_state_t      state_next;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;
  logic            found;
  int              idx;
  logic            last_q;
  logic            do_grant;
  logic            do_send;
  logic            do_release;
  logic            timeout_hit;
  logic [7:0]      lane_byte;
  logic            lane_last;
  logic            lane_req;

  assign busy      = (state != ARB_IDLE);
  assign dbg_state = state;

  // Round-robin pick: first requester at or after last_grant+1, wrapping at N_REQ.
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Select the owner's lane using the one-hot grant (zero lane when nobody owns the engine).
  always_comb begin
    lane_byte = 8'h00;
    lane_last = 1'b0;
    lane_req  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        lane_byte = req_byte[8*i +: 8];
        lane_last = req_last[i];
        lane_req  = req[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and one-cycle control strobes for the datapath.
  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    do_send    = 1'b0;
    do_release = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (|req) begin
          do_grant   = 1'b1;
          state_next = ARB_LOAD;
        end
      end
      ARB_LOAD: begin
        // Owner dropping req here ends its packet early without launching a byte.
        if (lane_req) begin
          do_send    = 1'b1;
          state_next = ARB_WAIT;
        end else begin
          do_release = 1'b1;
          state_next = ARB_IDLE;
        end
      end
      ARB_WAIT: begin
        // A completion in the same cycle as the watchdog expiry wins.
        if (tx_complete) begin
          if (last_q) begin
            do_release = 1'b1;
            state_next = ARB_IDLE;
          end else begin
            state_next = ARB_LOAD;
          end
        end else if (timeout_hit) begin
          do_release = 1'b1;
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Grant ownership, byte launch and release bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      grant_idx  <= '0;
      last_grant <= IW'(N_REQ - 1);
      byte_ack   <= '0;
      tx_start   <= 1'b0;
      tx_byte    <= 8'h00;
      last_q     <= 1'b0;
    end else begin
      tx_start <= do_send;
      byte_ack <= do_send ? grant : '0;
      if (do_grant) begin
        grant     <= ONE << pick;
        grant_idx <= pick;
      end
      if (do_send) begin
        tx_byte <= lane_byte;
        last_q  <= lane_last;
      end
      if (do_release) begin
        grant      <= '0;
        last_grant <= grant_idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 1'b1;

  logic [TIMEOUT_WIDTH-1:0] timeout_cnt;

  assign timeout_hit = (state == ARB_WAIT) && (timeout_cnt == TIMEOUT_LAST);

  // Watchdog counter: restarts when a byte is launched, counts every cycle spent waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    timeout_cnt <= '0;
    else if (do_send)           timeout_cnt <= '0;
    else if (state == ARB_WAIT) timeout_cnt <= timeout_cnt + 1'b1;
  end

  // Abort pulse, suppressed when the completion arrives in the expiry cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_err <= 1'b0;
    else     timeout_err <= timeout_hit && !tx_complete;
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
